// File: rtl/sa_readout_drain_if.sv
// Result stream port of sa_readout_drain: 8-bit beat with valid/ready handshake.
// master drives data/valid, slave drives ready.
interface sa_readout_drain_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/sa_readout_drain.sv
// sa_readout_drain: drives the systolic array's readout line for one full
// shift-out, captures the N result rows into a local buffer and then streams
// them as zero-extended 8-bit beats on a valid/ready port.
// Optional feature macro: DRAIN_POPCOUNT_EN -- appends one extra beat holding
// the total number of 1-bits over all captured rows.
module sa_readout_drain #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N-1:0]          sa_row_in,
  output logic                  sa_readout,
  sa_readout_drain_if.master    o_out,
  output logic                  busy,
  output logic                  done
);
  localparam int         IW     = $clog2(N);
  localparam logic [3:0] K_LAST = 4'(N + 1);  // last DRAIN step: sample for row N
  localparam logic [3:0] B_LAST = 4'(N - 1);  // index of last row beat

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SEND, S_FIN} state_t;

  state_t               r_state;
  logic [3:0]           r_k;      // DRAIN step: 0 raises readout, 1 is the discarded sample
  logic [3:0]           r_b;      // beat index in SEND
  logic [N-1:0][N-1:0]  r_buf;
  logic                 r_sa_readout;
  logic                 r_valid;
  logic [7:0]           r_data;
  logic                 r_busy;
  logic                 r_done;

  logic [IW-1:0]        w_cap_idx;
  logic [3:0]           w_b_nxt;
  logic [IW-1:0]        w_b_idx;
  logic [7:0]           w_row_nxt;
  logic [7:0]           w_row_first;

  // Step k samples row k-1 of the shift-out; row 0 of that is stale, so the
  // buffer slot trails the step by two.
  assign w_cap_idx   = IW'(r_k - 4'd2);
  assign w_b_nxt     = r_b + 4'd1;
  assign w_b_idx     = IW'(w_b_nxt);
  assign w_row_nxt   = 8'(r_buf[w_b_idx]);
  assign w_row_first = 8'(r_buf[0]);

`ifdef DRAIN_POPCOUNT_EN
  logic [7:0] r_pop;
  logic [7:0] w_pc;

  // Ones count of the row being sampled this cycle.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < N; i++) w_pc = w_pc + 8'(sa_row_in[i]);
  end
`endif

  // Control FSM; every output is a register so start/out_ready never reach
  // an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_b          <= '0;
      r_buf        <= '0;
      r_sa_readout <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef DRAIN_POPCOUNT_EN
      r_pop        <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DRAIN;
            r_k     <= '0;
            r_busy  <= 1'b1;
`ifdef DRAIN_POPCOUNT_EN
            r_pop   <= '0;
`endif
          end
        end
        S_DRAIN: begin
          r_k <= r_k + 4'd1;
          if (r_k == 4'd0) r_sa_readout <= 1'b1;
          if (r_k >= 4'd2) begin
            r_buf[w_cap_idx] <= sa_row_in;
`ifdef DRAIN_POPCOUNT_EN
            r_pop <= r_pop + w_pc;
`endif
          end
          // Row 0 was captured long ago, so it can be presented right away.
          if (r_k == K_LAST) begin
            r_sa_readout <= 1'b0;
            r_state      <= S_SEND;
            r_b          <= '0;
            r_valid      <= 1'b1;
            r_data       <= w_row_first;
          end
        end
        S_SEND: begin
          if (r_valid && o_out.out_ready) begin
            if (r_b == B_LAST) begin
`ifdef DRAIN_POPCOUNT_EN
              r_b     <= 4'(N);
              r_data  <= r_pop;
`else
              r_valid <= 1'b0;
              r_data  <= '0;
              r_state <= S_FIN;
`endif
            end
`ifdef DRAIN_POPCOUNT_EN
            else if (r_b == 4'(N)) begin
              r_valid <= 1'b0;
              r_data  <= '0;
              r_state <= S_FIN;
            end
`endif
            else begin
              r_b    <= w_b_nxt;
              r_data <= w_row_nxt;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sa_readout      = r_sa_readout;
  assign o_out.out_data  = r_data;
  assign o_out.out_valid = r_valid;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
